// File: rtl/gen_scheduler_pkg.sv
// Shared types and constants for the generation scheduler.
// Holds the FSM state and job enums, VGA count types, the frame-start
// decode and the watchdog width (used only when GEN_SCHED_WATCHDOG_EN is set).
package gen_scheduler_pkg;

  localparam int unsigned BOARD_SIZE  = 64;
  localparam int unsigned HCOUNT_W    = 11;
  localparam int unsigned VCOUNT_W    = 10;
  localparam int unsigned SEED_IDX_W  = 3;
  localparam int unsigned FRAME_CNT_W = 7;
  localparam int unsigned WD_W        = 24;

  typedef logic [HCOUNT_W-1:0]   hcount_t;
  typedef logic [VCOUNT_W-1:0]   vcount_t;
  typedef logic [SEED_IDX_W-1:0] seed_idx_t;

  typedef enum logic [1:0] {IDLE, GEN, SEED, SWAP_WAIT} sched_state_t;
  typedef enum logic {JOB_GEN, JOB_SEED} job_t;

  localparam hcount_t FRAME_START_H = '0;
  localparam vcount_t FRAME_START_V = '0;

  // First pixel of a frame.
  function automatic logic is_frame_start(hcount_t h, vcount_t v);
    return (h == FRAME_START_H) && (v == FRAME_START_V);
  endfunction

endpackage

// File: rtl/gen_scheduler_if.sv
// Bus between the scheduler and its environment (user input, updater,
// seed loader, board memory). The slave modport is the scheduler's view,
// the master modport is the environment's view.
interface gen_scheduler_if #(
  parameter int unsigned SPEED_WIDTH     = 3,
  parameter int unsigned GEN_COUNT_WIDTH = 16
);
  import gen_scheduler_pkg::*;

  hcount_t                    hcount_in;
  vcount_t                    vcount_in;
  logic                       pause_in;
  logic                       step_in;
  logic [SPEED_WIDTH-1:0]     speed_in;
  logic                       seed_req_in;
  seed_idx_t                  seed_idx_in;
  logic                       gen_done_in;
  logic                       seed_done_in;
  logic                       gen_start_out;
  logic                       seed_start_out;
  seed_idx_t                  seed_idx_out;
  logic                       rd_buf_out;
  logic                       wr_buf_out;
  logic                       busy_out;
  logic [GEN_COUNT_WIDTH-1:0] gen_count_out;

  modport master (
    output hcount_in, vcount_in, pause_in, step_in, speed_in,
           seed_req_in, seed_idx_in, gen_done_in, seed_done_in,
    input  gen_start_out, seed_start_out, seed_idx_out, rd_buf_out,
           wr_buf_out, busy_out, gen_count_out
  );

  modport slave (
    input  hcount_in, vcount_in, pause_in, step_in, speed_in,
           seed_req_in, seed_idx_in, gen_done_in, seed_done_in,
    output gen_start_out, seed_start_out, seed_idx_out, rd_buf_out,
           wr_buf_out, busy_out, gen_count_out
  );
endinterface

// File: rtl/gen_scheduler_frame_divider.sv
// Frame divider: counts frame starts while running and raises o_gen_tick_c
// (combinational, one cycle) every 2^i_speed frames.
// Ports: clk_in, rst_n_in, i_frame_start, i_pause, i_speed, o_gen_tick_c.
module gen_scheduler_frame_divider
  import gen_scheduler_pkg::*;
#(
  parameter int unsigned SPEED_WIDTH = 3
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   i_frame_start,
  input  logic                   i_pause,
  input  logic [SPEED_WIDTH-1:0] i_speed,
  output logic                   o_gen_tick_c
);

  localparam int unsigned LIM_W = FRAME_CNT_W + 1;

  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic [LIM_W-1:0]       w_limit;
  logic                   w_advance;
  logic                   w_at_limit;

  // >= rather than == so a lowered speed wraps at once instead of stalling.
  assign w_limit      = (LIM_W'(1) << i_speed) - LIM_W'(1);
  assign w_at_limit   = {1'b0, r_frame_cnt} >= w_limit;
  assign w_advance    = i_frame_start & ~i_pause;
  assign o_gen_tick_c = w_advance & w_at_limit;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_frame_cnt <= '0;
    end else if (w_advance) begin
      r_frame_cnt <= w_at_limit ? '0 : r_frame_cnt + FRAME_CNT_W'(1);
    end
  end

endmodule

// File: rtl/gen_scheduler.sv
// Generation scheduler: arbitrates updater and seed-loader access to the
// back buffer and swaps front/back only on a frame start.
// Ports: clk_in, rst_n_in (async active-low), bus (gen_scheduler_if.slave).
// Optional: GEN_SCHED_WATCHDOG_EN abandons a job after 2^24-1 cycles.
module gen_scheduler
  import gen_scheduler_pkg::*;
#(
  parameter int unsigned SPEED_WIDTH     = 3,
  parameter int unsigned GEN_COUNT_WIDTH = 16
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  gen_scheduler_if.slave bus
);

  sched_state_t               r_state;
  job_t                       r_last_job;
  logic                       r_gen_pend;
  logic                       r_seed_pend;
  seed_idx_t                  r_seed_idx;
  seed_idx_t                  r_seed_idx_out;
  logic                       r_gen_start;
  logic                       r_seed_start;
  logic                       r_rd_buf;
  logic                       r_busy;
  logic [GEN_COUNT_WIDTH-1:0] r_gen_count;

  logic w_frame_start;
  logic w_gen_tick;
  logic w_job_done;

`ifdef GEN_SCHED_WATCHDOG_EN
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_wd_trip;
`endif

  assign w_frame_start = is_frame_start(bus.hcount_in, bus.vcount_in);
  assign w_job_done    = ((r_state == GEN)  && bus.gen_done_in) ||
                         ((r_state == SEED) && bus.seed_done_in);

  gen_scheduler_frame_divider #(
    .SPEED_WIDTH (SPEED_WIDTH)
  ) u_frame_divider (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .i_frame_start (w_frame_start),
    .i_pause       (bus.pause_in),
    .i_speed       (bus.speed_in),
    .o_gen_tick_c  (w_gen_tick)
  );

  // Job FSM, pending flags and buffer swap.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state        <= IDLE;
      r_last_job     <= JOB_GEN;
      r_gen_pend     <= 1'b0;
      r_seed_pend    <= 1'b0;
      r_seed_idx     <= '0;
      r_seed_idx_out <= '0;
      r_gen_start    <= 1'b0;
      r_seed_start   <= 1'b0;
      r_rd_buf       <= 1'b0;
      r_busy         <= 1'b0;
      r_gen_count    <= '0;
`ifdef GEN_SCHED_WATCHDOG_EN
      r_wd_cnt       <= '0;
      r_wd_trip      <= 1'b0;
`endif
    end else begin
      r_gen_start  <= 1'b0;
      r_seed_start <= 1'b0;
      case (r_state)
        IDLE: begin
`ifdef GEN_SCHED_WATCHDOG_EN
          r_wd_cnt <= '0;
`endif
          // A seed load resets the board, so any pending generation is moot.
          if (r_seed_pend) begin
            r_state        <= SEED;
            r_busy         <= 1'b1;
            r_seed_start   <= 1'b1;
            r_seed_idx_out <= r_seed_idx;
            r_seed_pend    <= 1'b0;
            r_gen_pend     <= 1'b0;
          end else if (r_gen_pend) begin
            r_state     <= GEN;
            r_busy      <= 1'b1;
            r_gen_start <= 1'b1;
            r_gen_pend  <= 1'b0;
          end
        end
        GEN, SEED: begin
          if (w_job_done) begin
            r_state    <= SWAP_WAIT;
            r_last_job <= (r_state == SEED) ? JOB_SEED : JOB_GEN;
          end
`ifdef GEN_SCHED_WATCHDOG_EN
          else if (r_wd_cnt == '1) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_wd_trip <= 1'b1;
          end else begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
          end
`endif
        end
        SWAP_WAIT: begin
          if (w_frame_start) begin
            r_rd_buf    <= ~r_rd_buf;
            r_gen_count <= (r_last_job == JOB_GEN) ?
                           r_gen_count + GEN_COUNT_WIDTH'(1) : '0;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // New requests land after the FSM so one arriving on a dispatch edge is kept.
      if (w_gen_tick || (bus.step_in && bus.pause_in)) r_gen_pend <= 1'b1;
      if (bus.seed_req_in) begin
        r_seed_pend <= 1'b1;
        r_seed_idx  <= bus.seed_idx_in;
      end
    end
  end

  assign bus.gen_start_out  = r_gen_start;
  assign bus.seed_start_out = r_seed_start;
  assign bus.seed_idx_out   = r_seed_idx_out;
  assign bus.rd_buf_out     = r_rd_buf;
  assign bus.wr_buf_out     = ~r_rd_buf;
  assign bus.busy_out       = r_busy;
  assign bus.gen_count_out  = r_gen_count;

endmodule

// File: doc/gen_scheduler.md
Name: gen_scheduler

Overview:
Sequences generation updates and seed loads against the double-buffered board memory that feeds the renderer's cell_alive stream.
- Decides when the updater or the seed loader may write the back buffer.
- Swaps the front/back buffers only on a frame boundary, so a frame never tears.
- Sits between user input (pause, step, speed, seed select) and the updater, seed loader and board memory.

Parameters:
SPEED_WIDTH, 3, width of speed_in; generation period is 2^speed_in frames (1..128).
GEN_COUNT_WIDTH, 16, width of gen_count_out.

Ports:
clk_in  input  1  pixel clock; the only clock.
rst_n_in  input  1  asynchronous, active-low reset.
hcount_in  input  11  VGA horizontal count.
vcount_in  input  10  VGA vertical count.
pause_in  input  1  level; holds automatic generations.
step_in  input  1  one-cycle pulse; requests one generation while paused.
speed_in  input  SPEED_WIDTH  log2 of frames per generation.
seed_req_in  input  1  one-cycle pulse; requests a seed load.
seed_idx_in  input  3  seed pattern index, sampled with seed_req_in.
gen_done_in  input  1  updater finished writing the back buffer.
seed_done_in  input  1  seed loader finished writing the back buffer.
gen_start_out  output  1  one-cycle start pulse to the updater.
seed_start_out  output  1  one-cycle start pulse to the seed loader.
seed_idx_out  output  3  latched seed index; stable from seed_start_out until the next seed request is accepted.
rd_buf_out  output  1  buffer the renderer reads (front buffer).
wr_buf_out  output  1  buffer the writers target; always equal to ~rd_buf_out.
busy_out  output  1  high whenever state != IDLE.
gen_count_out  output  GEN_COUNT_WIDTH  generations displayed since the last seed load.

Behaviour:
- Reset (rst_n_in low, takes effect immediately, no clock needed):
  - state=IDLE; gen_pend=0; seed_pend=0; frame_cnt=0.
  - rd_buf_out=0, wr_buf_out=1.
  - Both start outputs 0; busy_out=0; seed_idx_out=0; gen_count_out=0.
- frame_start: combinational decode of hcount_in==0 && vcount_in==0. It is sampled at a clock edge.
- Frame divider (7-bit frame_cnt), acting at each sampled frame_start while pause_in=0:
  - If frame_cnt >= (1<<speed_in)-1: frame_cnt<=0 and gen_pend<=1.
  - Otherwise frame_cnt increments.
  - The >= compare means lowering speed_in never stalls the divider.
  - While pause_in=1, frame_cnt holds.
- step_in:
  - pause_in=1: sets gen_pend.
  - pause_in=0: ignored.
- Pending flags:
  - Setting a flag that is already set is a no-op; generations are dropped, never queued twice.
  - seed_req_in sets seed_pend and latches seed_idx_in into an internal register.
  - A seed_req_in arriving while a seed is already pending overwrites the latched index; the last request wins.
- FSM states and transitions:
  - IDLE:
    - seed_pend set: next state SEED; seed_start_out=1 for one cycle; seed_idx_out<=latched index; seed_pend<=0; gen_pend<=0.
    - else gen_pend set: next state GEN; gen_start_out=1 for one cycle; gen_pend<=0.
    - Seed has priority over generation.
  - GEN: gen_done_in -> SWAP_WAIT, last_job=GEN. New requests during GEN only set the pending flags.
  - SEED: seed_done_in -> SWAP_WAIT, last_job=SEED.
  - SWAP_WAIT, on sampled frame_start:
    - rd_buf_out toggles.
    - last_job=GEN: gen_count_out increments, wrapping at 2^GEN_COUNT_WIDTH.
    - last_job=SEED: gen_count_out<=0.
    - Next state IDLE.
- Latency: frame_start sampled at edge N -> gen_pend set at edge N -> gen_start_out high in the cycle after edge N+1.
- Done inputs:
  - A done asserted in the same cycle as frame_start moves the FSM to SWAP_WAIT only; the swap waits for the next frame_start.
  - Done inputs are ignored outside their own state.
- The buffer swap happens only in SWAP_WAIT. A job not finished by a frame_start defers the swap to a later frame; the renderer keeps showing the old front buffer.

Optional Feature:
Macro: GEN_SCHED_WATCHDOG_EN.
- Defined:
  - A 24-bit cycle counter runs in GEN and SEED.
  - On reaching 2^24-1 the job is abandoned: state returns to IDLE, no buffer swap, gen_count unchanged.
  - A sticky internal flag watchdog_trip is set; it clears only on reset.
- Undefined: no counter; GEN and SEED wait for their done input indefinitely.

Decomposition:
- Shared package:
  - sched_state_t enum {IDLE, GEN, SEED, SWAP_WAIT}.
  - job_t enum {JOB_GEN, JOB_SEED}.
  - Constants FRAME_START_H=0 and FRAME_START_V=0.
  - The existing BOARD_SIZE and hcount/vcount typedefs.
- One natural sub-module: frame_divider. It owns frame_cnt, speed_in and pause_in, and emits a one-cycle gen_tick.

Test Plan:
- Reset, speed_in=0, pause_in=0, frame_start at edge N -> gen_start_out high in the cycle after N+1. gen_done_in 100 cycles later -> rd_buf_out flips 0->1 at the next frame_start; gen_count_out=1.
- speed_in=2 held for 12 frames, gen_done_in returned promptly each time -> exactly 3 gen_start_out pulses, spaced by 4 frame_starts.
- pause_in=1, one step_in pulse -> exactly one gen_start_out. The next 10 frames produce none. A step_in with pause_in=0 produces no extra pulse.
- gen_done_in coincident with frame_start -> rd_buf_out unchanged that frame; flips at the following frame_start.
- seed_req_in with seed_idx_in=3 during GEN (gen_count_out=5) -> after the GEN swap, seed_start_out fires with seed_idx_out=3, and the pending generation is discarded. After seed_done_in and the next frame_start: gen_count_out=0.
- rst_n_in dropped mid-GEN with no clock edge -> all outputs at reset values immediately. After release, gen_done_in is ignored.
